// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data port arbiter in front of the unified memory.
// Latency: none (package). Backpressure: none (package).
// State encoding, word/byte-enable widths and the fetch-starvation bound default.
package mem_arb_pkg;

    localparam int WORD_W           = 32;
    localparam int BE_W             = 4;
    localparam int ADDR_W_DEF       = 10;
    localparam int MAX_DATA_RUN_DEF = 3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_WAIT = 2'd1,
        ARB_D_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_run_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
// Latency: count updates on the clock edge after inc/clr; at_max is combinational from the count.
// Backpressure: none; clr has priority over inc.
module arb_run_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_RUN = MAX_DATA_RUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int            CW    = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] MAX_V = CW'(MAX_RUN);

    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;

    always_comb begin
        run_d = run_q;
        if (clr_i) begin
            run_d = '0;
        end else if (inc_i && (run_q != MAX_V)) begin
            run_d = run_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign at_max_o = (run_q == MAX_V);

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-ported synchronous memory.
// Latency: ready pulses exactly one cycle after the grant; one access per two cycles.
// Backpressure: requests are held by the requester until its ready pulse; data wins unless the fetch has starved MAX_DATA_RUN grants.
module imem_dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [BE_W-1:0]   d_be,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       run_inc;
    logic       run_clr;
    logic       run_at_max;

    // Byte offset and bits above the memory size are dropped, so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    arb_run_counter #(
        .MAX_RUN (MAX_DATA_RUN)
    ) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (run_inc),
        .clr_i    (run_clr),
        .at_max_o (run_at_max)
    );

    always_comb begin
        state_d   = state_q;
        run_inc   = 1'b0;
        run_clr   = 1'b0;
        if_ready  = 1'b0;
        if_rdata  = '0;
        d_ready   = 1'b0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        // Gating on rst suppresses both a new grant and a ready for an interrupted access.
        if (!rst) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (d_req && (!if_req || !run_at_max)) begin
                        mem_en    = 1'b1;
                        mem_we    = d_we;
                        mem_be    = d_we ? d_be : '0;
                        mem_addr  = d_addr[ADDR_W+1:2];
                        mem_wdata = d_wdata;
                        run_inc   = if_req;
                        run_clr   = !if_req;
                        state_d   = ARB_D_WAIT;
                    end else if (if_req) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr[ADDR_W+1:2];
                        run_clr  = 1'b1;
                        state_d  = ARB_IF_WAIT;
                    end
                end
                ARB_IF_WAIT: begin
                    if_ready = 1'b1;
                    if_rdata = mem_rdata;
                    state_d  = ARB_IDLE;
                end
                ARB_D_WAIT: begin
                    d_ready = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = ARB_IDLE;
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/responses, a negedge monitor checks them.
module tb_imem_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    imem_dmem_port_arbiter #(
        .ADDR_W       (10),
        .MAX_DATA_RUN (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_be      (d_be),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous single-port memory: read data valid the cycle after mem_en.
    logic [31:0] mem_model [0:1023];
    logic [31:0] rdata_q;
    assign mem_rdata = rdata_q;

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        mem_model[1] = 32'h0000_2083;
        mem_model[2] = 32'h00A0_0093;
        rdata_q = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            rdata_q <= mem_model[mem_addr];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic prev_en   = 1'b0;
    logic prev_is_d = 1'b0;

    always @(negedge clk) begin
        grant_t g;
        resp_t  r;
        if (rst) begin
            check("reset_quiet", {61'h0, mem_en, if_ready, d_ready}, 64'h0);
            prev_en = 1'b0;
        end else begin
            if (prev_en) check("ready_after_grant", {62'h0, if_ready, d_ready},
                               prev_is_d ? 64'h1 : 64'h2);
            if (if_ready || d_ready) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_ready", {62'h0, if_ready, d_ready}, 64'h0);
                end else begin
                    r = resp_q.pop_front();
                    check("ready_kind", {62'h0, if_ready, d_ready}, r.is_d ? 64'h1 : 64'h2);
                    if (r.chk) check("rdata", {32'h0, r.is_d ? d_rdata : if_rdata}, {32'h0, r.data});
                end
            end
            check("rdata_gated", {if_ready ? 32'h0 : if_rdata, d_ready ? 32'h0 : d_rdata}, 64'h0);
            if (mem_en) begin
                check("no_back_to_back", {63'h0, prev_en}, 64'h0);
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", {63'h0, mem_en}, 64'h0);
                    prev_is_d = 1'b0;
                end else begin
                    g = grant_q.pop_front();
                    check("grant", {17'h0, mem_we, mem_be, mem_addr, g.is_d ? mem_wdata : 32'h0},
                          {17'h0, g.we, g.be, g.addr, g.wdata});
                    prev_is_d = g.is_d;
                end
            end else begin
                check("mem_idle", {mem_we, mem_be, mem_addr, mem_wdata}, 64'h0);
            end
            prev_en = mem_en;
        end
    end

    task automatic expect_access(input bit is_d, input bit we, input logic [3:0] be,
                                 input logic [9:0] word, input logic [31:0] wdata,
                                 input logic [31:0] rdata);
        grant_t g;
        resp_t  r;
        g = '{is_d: is_d, we: we, be: be, addr: word, wdata: is_d ? wdata : 32'h0};
        r = '{is_d: is_d, chk: !we, data: rdata};
        grant_q.push_back(g);
        resp_q.push_back(r);
    endtask

    task automatic wait_ready(input bit is_d, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(is_d ? d_ready : if_ready) && cyc < 20);
        if (!(is_d ? d_ready : if_ready)) check(is_d ? "d_ready_timeout" : "if_ready_timeout", 64'h0, 64'h1);
    endtask

    // One isolated access; exp_be is the byte-enable the memory must see.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [3:0] exp_be, input logic [31:0] wdata,
                          input logic [9:0] word, input logic [31:0] rdata);
        int cyc;
        expect_access(is_d, we, exp_be, word, wdata, rdata);
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_ready(is_d, cyc);
        check("access_latency", 64'(cyc), 64'd2);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int cyc;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", {if_ready, d_ready, mem_en, mem_we, mem_be, mem_addr},
              64'h0);

        // 1: fetch word 1
        access(1'b0, 1'b0, 32'h0000_0004, 4'h0, 4'h0, 32'h0, 10'd1, 32'h0000_2083);

        // 2: store then load word 3
        access(1'b1, 1'b1, 32'h0000_000C, 4'hF, 4'hF, 32'h1234_5678, 10'd3, 32'h0);
        access(1'b1, 1'b0, 32'h0000_000C, 4'hF, 4'h0, 32'h0, 10'd3, 32'h1234_5678);

        // 3: both held -> D,D,D,IF,D,D,D,IF
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) expect_access(1'b0, 1'b0, 4'h0, 10'd2, 32'h0, 32'h00A0_0093);
            else                  expect_access(1'b1, 1'b0, 4'h0, 10'd3, 32'h0, 32'h1234_5678);
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0008;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_000C; d_be = 4'hF;
        cnt = 0; cyc = 0;
        while (cnt < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_ready || d_ready) cnt++;
        end
        check("run_ready_count", 64'(cnt), 64'd8);
        check("run_cycles", 64'(cyc), 64'd16);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;

        // 4: data-only pulses, then simultaneous request gives data priority
        access(1'b1, 1'b1, 32'h0000_0014, 4'h3, 4'h3, 32'hAAAA_BBBB, 10'd5, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0014, 4'hF, 4'h0, 32'h0, 10'd5, 32'h0000_BBBB);
        access(1'b1, 1'b0, 32'h0000_000C, 4'hF, 4'h0, 32'h0, 10'd3, 32'h1234_5678);
        expect_access(1'b1, 1'b0, 4'h0, 10'd5, 32'h0, 32'h0000_BBBB);
        expect_access(1'b0, 1'b0, 4'h0, 10'd1, 32'h0, 32'h0000_2083);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0014;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        wait_ready(1'b1, cyc);
        check("prio_d_latency", 64'(cyc), 64'd2);
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_ready(1'b0, cyc);
        check("prio_if_latency", 64'(cyc), 64'd2);
        @(posedge clk); #1;
        if_req = 1'b0;

        // 5: reset while in IF_WAIT
        begin
            grant_t g;
            g = '{is_d: 1'b0, we: 1'b0, be: 4'h0, addr: 10'd1, wdata: 32'h0};
            grant_q.push_back(g);
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        @(negedge clk);
        check("rst_case_grant", {63'h0, mem_en}, 64'h1);
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("rst_no_if_ready", {63'h0, if_ready}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_all_zero", {if_ready, d_ready, mem_en, mem_we, mem_be, mem_addr,
                               if_rdata[15:0], d_rdata[15:0], mem_wdata[8:0]}, 64'h0);
        access(1'b0, 1'b0, 32'h0000_0008, 4'h0, 4'h0, 32'h0, 10'd2, 32'h00A0_0093);

        // 6: out-of-range, misaligned fetch wraps to word 1
        access(1'b0, 1'b0, 32'h0000_1006, 4'h0, 4'h0, 32'h0, 10'd1, 32'h0000_2083);

        repeat (3) @(negedge clk);
        check("grant_queue_drained", 64'(grant_q.size()), 64'd0);
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
